// File: rtl/seed_pkg.sv
// Shared definitions for the iterative SEED core: S-boxes, key constants,
// G-function masks and the controller state type.
package seed_pkg;

    typedef enum logic [1:0] {IDLE, KEY, ROUND, DONE} state_t;

    localparam logic [7:0] M0 = 8'hFC;
    localparam logic [7:0] M1 = 8'hF3;
    localparam logic [7:0] M2 = 8'hCF;
    localparam logic [7:0] M3 = 8'h3F;

    localparam logic [31:0] KC [16] = '{
        32'h9E3779B9, 32'h3C6EF373, 32'h78DDE6E6, 32'hF1BBCDCC,
        32'hE3779B99, 32'hC6EF3733, 32'h8DDE6E67, 32'h1BBCDCCF,
        32'h3779B99E, 32'h6EF3733C, 32'hDDE6E678, 32'hBBCDCCF1,
        32'h779B99E3, 32'hEF3733C6, 32'hDE6E678D, 32'hBCDCCF1B
    };

    localparam int unsigned S1_TAB [256] = '{
        169,133,214,211, 84, 29,172, 37, 93, 67, 24, 30, 81,252,202, 99,
         40, 68, 32,157,224,226,200, 23,165,143,  3,123,187, 19,210,238,
        112,140, 63,168, 50,221,246,116,236,149, 11, 87, 92, 91,189,  1,
         36, 28,115,152, 16,204,242,217, 44,231,114,131,155,209,134,201,
         96, 80,163,235, 13,182,158, 79,183, 90,198,120,166, 18,175,213,
         97,195,180, 65, 82,125,141,  8, 31,153,  0, 25,  4, 83,247,225,
        253,118, 47, 39,176,139, 14,171,162,110,147, 77,105,124,  9, 10,
        191,239,243,197,135, 20,254,100,222, 46, 75, 26,  6, 33,107,102,
          2,245,146,138, 12,179,126,208,122, 71,150,229, 38,128,173,223,
        161, 48, 55,174, 54, 21, 34, 56,244,167, 69, 76,129,233,132,151,
         53,203,206, 60,113, 17,199,137,117,251,218,248,148, 89,130,196,
        255, 73, 57,103,192,207,215,184, 15,142, 66, 35,145,108,219,164,
         52,241, 72,194,111, 61, 45, 64,190, 62,188,193,170,186, 78, 85,
         59,220,104,127,156,216, 74, 86,119,160,237, 70,181, 43,101,250,
        227,185,177,159, 94,249,230,178, 49,234,109, 95,228,240,205,136,
         22, 58, 88,212, 98, 41,  7, 51,232, 27,  5,121,144,106, 42,154
    };

    localparam int unsigned S2_TAB [256] = '{
         56,232, 45,166,207,222,179,184,175, 96, 85,199, 68,111,107, 91,
        195, 98, 51,181, 41,160,226,167,211,145, 17,  6, 28,188, 54, 75,
        239,136,108,168, 23,196, 22,244,194, 69,225,214, 63, 61,142,152,
         40, 78,246, 62,165,249, 13,223,216, 43,102,122, 39, 47,241,114,
         66,212, 65,192,115,103,172,139,247,173,128, 31,202, 44,170, 52,
        210, 11,238,233, 93,148, 24,248, 87,174,  8,197, 19,205,134,185,
        255,125,193, 49,245,138,106,177,209, 32,215,  2, 34,  4,104,113,
          7,219,157,153, 97,190,230, 89,221, 81,144,220,154,163,171,208,
        129, 15, 71, 26,227,236,141,191,150,123, 92,162,161, 99, 35, 77,
        200,158,156, 58, 12, 46,186,110,159, 90,242,146,243, 73,120,204,
         21,251,112,117,127, 53, 16,  3,100,109,198,116,213,180,234,  9,
        118, 25,254, 64, 18,224,189,  5,250,  1,240, 42, 94,169, 86, 67,
        133, 20,137,155,176,229, 72,121,151,252, 30,130, 33,140, 27, 95,
        119, 84,178, 29, 37, 79,  0, 70,237, 88, 82,235,126,218,201,253,
         48,149,101, 60,182,228,187,124, 14, 80, 57, 38, 50,132,105,147,
         55,231, 36,164,203, 83, 10,135,217, 76,131,143,206, 59, 74,183
    };

    function automatic logic [7:0] s1(input logic [7:0] x);
        int unsigned v;
        v = S1_TAB[x];
        return v[7:0];
    endfunction

    function automatic logic [7:0] s2(input logic [7:0] x);
        int unsigned v;
        v = S2_TAB[x];
        return v[7:0];
    endfunction

endpackage

// File: rtl/seed_g.sv
// SEED G function: four S-box lookups followed by the masked byte mixing.
module seed_g
    import seed_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [7:0] y0, y1, y2, y3;

    always_comb begin
        y0 = s1(x[7:0]);
        y1 = s2(x[15:8]);
        y2 = s1(x[23:16]);
        y3 = s2(x[31:24]);
        y[7:0]   = (y0 & M0) ^ (y1 & M1) ^ (y2 & M2) ^ (y3 & M3);
        y[15:8]  = (y0 & M1) ^ (y1 & M2) ^ (y2 & M3) ^ (y3 & M0);
        y[23:16] = (y0 & M2) ^ (y1 & M3) ^ (y2 & M0) ^ (y3 & M1);
        y[31:24] = (y0 & M3) ^ (y1 & M0) ^ (y2 & M1) ^ (y3 & M2);
    end

endmodule

// File: rtl/seed128_core.sv
// Iterative SEED-128 encrypt/decrypt core, one Feistel round per clock.
// Text arrives on i_Data with the start strobe, the key on the following cycle.
module seed128_core
    import seed_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic [127:0] i_Data,
    input  logic         i_fStart,
    input  logic         i_fDec,
    output logic [127:0] o_Data,
    output logic         o_fDone
);

    state_t      state, state_nx;
    logic [63:0] l_q, r_q;
    logic [31:0] key_a, key_b, key_c, key_d;
    logic        dec_q;
    logic [3:0]  rnd_q;
    logic        load_text, load_key, do_round, last_round;

    logic [63:0]  ab, cd;
    logic [127:0] key_nx;
    logic [31:0]  kconst, k0, k1, t0, t1, ga, gb, gc;
    logic [63:0]  f_out;

    assign last_round = (rnd_q == 4'd15);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_fStart)   state_nx = KEY;
            KEY:     if (!i_fStart)  state_nx = ROUND;
            ROUND:   if (last_round) state_nx = DONE;
            DONE:                    state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_text = (state == IDLE) && i_fStart;
        load_key  = (state == KEY) && !i_fStart;
        do_round  = (state == ROUND);
        o_fDone   = (state == DONE);
    end

    // Decrypt walks the schedule backwards: undo forward step 16-rnd, then
    // derive the round key from the restored state, so both directions take 16 cycles.
    always_comb begin
        ab     = {key_a, key_b};
        cd     = {key_c, key_d};
        kconst = KC[rnd_q];
        if (dec_q) begin
            kconst = KC[4'd15 - rnd_q];
            if (rnd_q[0]) ab = {ab[55:0], ab[63:56]};
            else          cd = {cd[7:0], cd[63:8]};
            key_nx = {ab, cd};
        end else if (!rnd_q[0]) begin
            key_nx = {ab[7:0], ab[63:8], cd};
        end else begin
            key_nx = {ab, cd[55:0], cd[63:56]};
        end
    end

    seed_g u_gk0 (.x(ab[63:32] + cd[63:32] - kconst), .y(k0));
    seed_g u_gk1 (.x(ab[31:0] - cd[31:0] + kconst),   .y(k1));

    assign t0 = r_q[63:32] ^ k0;
    assign t1 = r_q[31:0] ^ k1;

    seed_g u_ga (.x(t0 ^ t1), .y(ga));
    seed_g u_gb (.x(ga + t0), .y(gb));
    seed_g u_gc (.x(ga + gb), .y(gc));

    assign f_out = {gc + gb, gc};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            l_q    <= '0;
            r_q    <= '0;
            key_a  <= '0;
            key_b  <= '0;
            key_c  <= '0;
            key_d  <= '0;
            dec_q  <= 1'b0;
            rnd_q  <= '0;
            o_Data <= '0;
        end else begin
            if (load_text) begin
                l_q   <= i_Data[127:64];
                r_q   <= i_Data[63:0];
                dec_q <= i_fDec;
                rnd_q <= '0;
            end
            if (load_key) begin
                {key_a, key_b, key_c, key_d} <= i_Data;
                rnd_q <= '0;
            end
            if (do_round) begin
                {key_a, key_b, key_c, key_d} <= key_nx;
                rnd_q <= rnd_q + 4'd1;
                if (last_round) begin
                    l_q    <= l_q ^ f_out;
                    o_Data <= {l_q ^ f_out, r_q};
                end else begin
                    l_q <= r_q;
                    r_q <= l_q ^ f_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_seed128_core.sv
// Self-checking bench for seed128_core: directed known-answer vectors checked
// against a block-level SEED model plus per-cycle done/data tracking.
module tb_seed128_core;
    import seed_pkg::*;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [127:0] i_Data = '0;
    logic         i_fStart = 1'b0;
    logic         i_fDec = 1'b0;
    logic [127:0] o_Data;
    logic         o_fDone;

    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    int           edge_cnt = 0;
    int           done_edge = -1;
    logic [127:0] exp_data = '0;
    logic [127:0] pend = '0;

    localparam logic [31:0] MASK_WORD = 32'h3FCFF3FC;

    seed128_core dut (
        .Clk(Clk), .Rst(Rst), .i_Data(i_Data), .i_fStart(i_fStart),
        .i_fDec(i_fDec), .o_Data(o_Data), .o_fDone(o_fDone)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) edge_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
    endfunction

    function automatic logic [31:0] mg(input logic [31:0] x);
        logic [31:0] acc;
        logic [7:0]  b;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            b = (i % 2 == 0) ? s1(x[8*i +: 8]) : s2(x[8*i +: 8]);
            acc ^= {4{b}} & ror32(MASK_WORD, 8 * i);
        end
        return acc;
    endfunction

    function automatic logic [63:0] mf(input logic [31:0] k0, input logic [31:0] k1, input logic [63:0] r);
        logic [31:0] t0, a, b, c;
        t0 = r[63:32] ^ k0;
        a  = mg(t0 ^ r[31:0] ^ k1);
        b  = mg(a + t0);
        c  = mg(a + b);
        return {c + b, c};
    endfunction

    // Whole-block reference: full key schedule first, then 16 rounds with the
    // key list read forwards or backwards.
    function automatic logic [127:0] model(input logic [127:0] text, input logic [127:0] key, input logic dec);
        logic [31:0] rk0 [16];
        logic [31:0] rk1 [16];
        logic [63:0] ab, cd, l, r, tmp;
        int j;
        ab = key[127:64];
        cd = key[63:0];
        for (int i = 0; i < 16; i++) begin
            rk0[i] = mg(ab[63:32] + cd[63:32] - KC[i]);
            rk1[i] = mg(ab[31:0] - cd[31:0] + KC[i]);
            if (i % 2 == 0) ab = {ab[7:0], ab[63:8]};
            else            cd = {cd[55:0], cd[63:56]};
        end
        l = text[127:64];
        r = text[63:0];
        for (int i = 0; i < 16; i++) begin
            j = dec ? 15 - i : i;
            tmp = l ^ mf(rk0[j], rk1[j], r);
            if (i == 15) l = tmp;
            else begin
                l = r;
                r = tmp;
            end
        end
        return {l, r};
    endfunction

    always @(negedge Clk) begin
        logic exp_done;
        exp_done = (edge_cnt == done_edge);
        if (exp_done) exp_data = pend;
        chk("done_pulse", {127'd0, o_fDone}, {127'd0, exp_done});
        chk("data_hold", o_Data, exp_data);
    end

    task automatic run_op(input logic [127:0] text, input logic [127:0] key, input logic dec,
                          input int hold, input bit toggle, input logic [127:0] lit);
        logic [127:0] m;
        m = model(text, key, dec);
        chk("model_vs_literal", m, lit);
        i_Data    = text;
        i_fDec    = dec;
        i_fStart  = 1'b1;
        pend      = lit;
        done_edge = edge_cnt + 18 + hold;
        @(posedge Clk); #2;
        i_fDec = ~dec;
        i_Data = ~text;
        repeat (hold) begin @(posedge Clk); #2; end
        i_fStart = 1'b0;
        i_Data   = key;
        @(posedge Clk); #2;
        i_Data = ~key;
        for (int c = 0; c < 16; c++) begin
            if (toggle) i_fStart = 1'($urandom_range(0, 1));
            @(posedge Clk); #2;
        end
        i_fStart = 1'b0;
        chk("result_literal", o_Data, lit);
        @(posedge Clk); #2;
    endtask

    initial begin
        #1 Rst = 1'b0;
        #16 Rst = 1'b1;
        @(posedge Clk); #2;

        run_op(128'h0, 128'h000102030405060708090A0B0C0D0E0F, 1'b0, 0, 1'b0,
               128'hC11F22F201405050_84483597E4370F43);
        run_op(128'h83A2F8A288641FB9_A4E9A5CC2F131C7D, 128'h4706480851E61BE8_5D74BFB3FD956185, 1'b0, 0, 1'b0,
               128'hEE54D13EBCAE706D_226BC3142CD40D4A);
        run_op(128'hC11F22F201405050_84483597E4370F43, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 0, 1'b0,
               128'h0);
        run_op(128'h9B9B7BFCD1813CB9_5D0B3618F40F5122, 128'h28DBC3BC49FFD87D_CFA509B11D422BE7, 1'b1, 0, 1'b0,
               128'hB41E6BE2EBA84A14_8E2EED84593C5EC7);
        run_op(128'h000102030405060708090A0B0C0D0E0F, 128'h0, 1'b0, 2, 1'b0,
               128'h5EBAC6E0054E1668_19AFF1CC6D346CDB);
        run_op(128'h83A2F8A288641FB9_A4E9A5CC2F131C7D, 128'h4706480851E61BE8_5D74BFB3FD956185, 1'b0, 0, 1'b1,
               128'hEE54D13EBCAE706D_226BC3142CD40D4A);

        // Abort during round 8: outputs must clear at once and no done may follow.
        i_Data    = 128'h0;
        i_fDec    = 1'b0;
        i_fStart  = 1'b1;
        pend      = 128'hC11F22F201405050_84483597E4370F43;
        done_edge = edge_cnt + 18;
        @(posedge Clk); #2;
        i_fStart = 1'b0;
        i_Data   = 128'h000102030405060708090A0B0C0D0E0F;
        @(posedge Clk); #2;
        repeat (8) begin @(posedge Clk); #2; end
        Rst       = 1'b0;
        done_edge = -1;
        exp_data  = '0;
        #1;
        chk("reset_data", o_Data, 128'h0);
        chk("reset_done", {127'd0, o_fDone}, 128'h0);
        @(posedge Clk); #2;
        Rst = 1'b1;
        repeat (20) begin @(posedge Clk); #2; end

        run_op(128'h9B9B7BFCD1813CB9_5D0B3618F40F5122, 128'h28DBC3BC49FFD87D_CFA509B11D422BE7, 1'b1, 1, 1'b0,
               128'hB41E6BE2EBA84A14_8E2EED84593C5EC7);
        repeat (3) begin @(posedge Clk); #2; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seed128_core.md
# seed128_core

Iterative SEED (RFC 4269) 128-bit block cipher core. It encrypts or decrypts one block per request, computing one Feistel round per clock. The key is delivered over the same 128-bit data bus as the block, one cycle after the block. It is a standalone crypto leaf for a datapath or bus-wrapper that supplies block and key serially.

## Interface
- No parameters.
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous active-low reset.
- i_Data  in  128  first the text block, then the key (MSB = byte 0).
- i_fStart  in  1  request strobe.
- i_fDec  in  1  0 = encrypt, 1 = decrypt; sampled with the start.
- o_Data  out  128  result; holds its value until the next result.
- o_fDone  out  1  one-cycle completion pulse.

## Operation
- FSM: IDLE, KEY, ROUND, DONE.
- IDLE:
  - on i_fStart=1, latch i_Data as text (L = [127:64], R = [63:0]) and latch i_fDec.
  - clear round counter; go to KEY.
- KEY:
  - at the first edge with i_fStart=0, latch i_Data as key state A,B,C,D (A = [127:96]); go to ROUND.
  - while i_fStart stays 1, stay in KEY.
- ROUND: 16 cycles, round i = 1..16.
  - Round key pair: Ki0 = G(A+C−KC[i−1]) and Ki1 = G(B−D+KC[i−1]); all arithmetic is mod 2^32.
  - Encrypt, key state update: after round i, rotate A||B right by 8 if i is odd; rotate C||D left by 8 if i is even.
  - Decrypt: the key state after 16 forward steps equals the original key. Round j uses K(17−j).
  - Decrypt, key state update: before round j, undo forward step 17−j (C||D right by 8 when 17−j is even, A||B left by 8 when odd). Then use KC[16−j].
  - Decrypt latency equals encrypt latency.
- F(K0,K1,R = C||D):
  - t0 = C^K0; a = G(t0^D^K1); b = G(a+t0); c = G(a+b).
  - F = (c+b)||c.
- Feistel rounds 1–15: L,R ← R, L^F(K,R).
- Round 16: L ← L^F(K,R), no swap.
- Result: o_Data = L||R.
- G(X3..X0):
  - Y0 = S1(X0), Y1 = S2(X1), Y2 = S1(X2), Y3 = S2(X3).
  - Masks m0..m3 = FC, F3, CF, 3F.
  - Zk = (Y0&m(k)) ^ (Y1&m(k+1)) ^ (Y2&m(k+2)) ^ (Y3&m(k+3)), indices mod 4.
  - G = Z3||Z2||Z1||Z0.
- KC constants: 9E3779B9, 3C6EF373, 78DDE6E6, F1BBCDCC, E3779B99, C6EF3733, 8DDE6E67, 1BBCDCCF, 3779B99E, 6EF3733C, DDE6E678, BBCDCCF1, 779B99E3, EF3733C6, DE6E678D, BCDCCF1B.
- i_fStart is ignored while the core is in KEY (after latching), ROUND or DONE.

## Timing
- Reset values: o_Data = 0, o_fDone = 0, FSM in IDLE, all internal registers 0.
- Cycle-level latency:
  - Start accepted at edge T0.
  - Key latched at edge T1 (i_fStart low at T1).
  - Rounds at edges T2..T17.
  - o_Data and o_fDone are registered at T17.
- o_fDone is high for exactly the cycle after T17. The FSM passes through DONE and returns to IDLE at T18.
- A new start is accepted from T18 on.
- Reset asserted mid-operation aborts immediately and restores all reset values; no done pulse follows.

## Structure
- Shared package seed_pkg holds:
  - the S1/S2 256×8 tables (RFC 4269);
  - the KC[0:15] constant array;
  - the masks;
  - the FSM state enum.
- One sub-module, seed_g: combinational G function.
  - Instantiated 5× (two key, three F).
  - Top holds the FSM, key/round registers and F glue.

## Test plan
- Encrypt: text 0, key 00010203_04050607_08090A0B_0C0D0E0F. Expect o_Data = C11F22F2_01405050_84483597_E4370F43 and o_fDone 17 cycles after the key edge.
- Encrypt: text 83A2F8A2_88641FB9_A4E9A5CC_2F131C7D, key 47064808_51E61BE8_5D74BFB3_FD956185. Expect EE54D13E_BCAE706D_226BC314_2CD40D4A.
- Decrypt: text C11F22F2_01405050_84483597_E4370F43, key 00010203_04050607_08090A0B_0C0D0E0F. Expect all-zero output, same latency as encrypt.
- Decrypt: text 9B9B7BFC_D1813CB9_5D0B3618_F40F5122, key 28DBC3BC_49FFD87D_CFA509B1_1D422BE7. Expect B41E6BE2_EBA84A14_8E2EED84_593C5EC7.
- Encrypt: key 0, text 00010203_04050607_08090A0B_0C0D0E0F. Expect 5EBAC6E0_054E1668_19AFF1CC_6D346CDB.
- Robustness:
  - pulse Rst low during round 8: o_Data = 0 and no o_fDone;
  - toggle i_fStart during rounds: the result is unchanged.
